controlador_memoria: RTL and testbench
======================================

# controlador_memoria

Load/store sequencer that drives the 8-bit data memory port on behalf of the datapath. It accepts a single-word or burst request (base address plus count), generates the memory control strobes and addresses, and returns read data or consumes write data over simple valid/accept handshakes. It sits between the control unit/datapath and the data memory, and is the only initiator on that memory port.

## Interface
- LARG_QTD, 5, width of the burst count (bursts of 0..2^LARG_QTD-1 words)
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Inicio  in  1  request strobe; sampled only in OCIOSO
- Escrita  in  1  request type: 1 = store, 0 = load; sampled with Inicio
- EnderecoBase  in  8  first word address; sampled with Inicio
- Quantidade  in  LARG_QTD  number of words; sampled with Inicio
- DadoEntrada  in  8  store data from datapath
- DadoEntradaValido  in  1  DadoEntrada holds a valid word
- DadoEntradaAceito  out  1  controller takes DadoEntrada this cycle
- DadoSaida  out  8  load data to datapath (registered)
- DadoSaidaValido  out  1  one-cycle pulse per loaded word; no backpressure
- Ocupado  out  1  high in every state except OCIOSO
- Concluido  out  1  one-cycle pulse at end of request
- Endereco  out  8  memory address (registered)
- DadoEscritoMem  out  8  memory write data (registered)
- EscMem  out  1  memory write enable (registered)
- LerMem  out  1  memory read enable (registered)
- DadoLidoMem  in  8  memory read data

## Operation
- Memory-side contract: memory writes on the rising edge when EscMem=1; memory reads on the falling edge when LerMem=1 and holds DadoLidoMem until the next read.
- States: OCIOSO, LEITURA, ESPERA_DADO, ESCRITA, FIM.
- OCIOSO: Inicio=1 latches Escrita, EnderecoBase (into address counter), Quantidade (into remaining counter). Quantidade=0 -> FIM. Escrita=0 -> LEITURA, else ESPERA_DADO. Inicio=0 -> stay.
- LEITURA: LerMem=1, Endereco=address counter. Each cycle: address+1 (mod 256), remaining-1; remaining reaching 0 -> FIM. Back-to-back reads, one word per cycle.
- Load capture: on the rising edge ending every LEITURA cycle, DadoSaida <= DadoLidoMem, DadoSaidaValido <= 1 for the next cycle only.
- ESPERA_DADO: DadoEntradaAceito=1 (Moore), EscMem=0. DadoEntradaValido=1 -> DadoEscritoMem <= DadoEntrada, Endereco <= address, EscMem <= 1, go ESCRITA. Otherwise wait indefinitely.
- ESCRITA: EscMem=1 for exactly one cycle; memory commits at the edge leaving ESCRITA. address+1 (mod 256), remaining-1; remaining 0 -> FIM, else ESPERA_DADO.
- FIM: Concluido=1 for one cycle, Ocupado=1, strobes 0; -> OCIOSO.
- Address wrap: 8'hFF increments to 8'h00; no error flag.
- Inicio outside OCIOSO: ignored, no queuing. Inicio held high: new request accepted on the cycle after FIM.
- DadoEntradaAceito=0 outside ESPERA_DADO; DadoEntradaValido there is ignored.

## Timing
- Reset values: DadoEntradaAceito 0, DadoSaida 8'h00, DadoSaidaValido 0, Ocupado 0, Concluido 0, Endereco 8'h00, DadoEscritoMem 8'h00, EscMem 0, LerMem 0; state OCIOSO; counters 0.
- Load, Inicio sampled at edge 0: LerMem high cycles 1..N, first DadoSaidaValido in cycle 2, last in cycle N+1 coinciding with Concluido; Ocupado low from cycle N+2.
- Store: 2 cycles per word when DadoEntradaValido stays high; Concluido in the cycle after the last ESCRITA.
- Quantidade=0: Concluido in cycle 1, no strobes.
- Reset mid-operation: all outputs return to reset values at the reset edge. A write whose ESCRITA cycle coincides with the reset edge still commits (memory samples the same edge). No further accesses, no Concluido, no DadoSaidaValido after that edge.
- EscMem and LerMem are never high in the same cycle.

## Test plan
- Mem[0x10..0x12]=0xA1,0xB2,0xC3; load base 0x10, qty 3 -> LerMem high 3 cycles at 0x10,0x11,0x12; DadoSaidaValido cycles 2,3,4 with 0xA1,0xB2,0xC3; Concluido cycle 4.
- Store base 0x20, qty 2, DadoEntradaValido held high with 0x55 then 0x66 -> EscMem pulses at 0x20,0x21; readback gives 0x55,0x66; Concluido 5 cycles after Inicio.
- Store with DadoEntradaValido delayed 3 cycles -> stays in ESPERA_DADO with Aceito=1, EscMem=0 until valid; then one write.
- Load base 0xFE, qty 3 -> addresses 0xFE,0xFF,0x00.
- Quantidade=0 -> Concluido cycle 1, no strobes; Inicio during a burst -> ignored, only one Concluido.
- Reset asserted during ESCRITA of word 2 of a 4-word store -> words 1-2 written, words 3-4 untouched, all outputs at reset values, no Concluido.

Source files
------------

// File: rtl/controlador_memoria.sv
// Load/store sequencer for the 8-bit data memory port: runs single-word or burst
// requests, drives registered memory strobes/address and hands data to/from the datapath.
module controlador_memoria #(
  parameter int LARG_QTD = 5
) (
  input  logic                Clock_i,
  input  logic                Reset_i,
  input  logic                Inicio_i,
  input  logic                Escrita_i,
  input  logic [7:0]          EnderecoBase_i,
  input  logic [LARG_QTD-1:0] Quantidade_i,
  input  logic [7:0]          DadoEntrada_i,
  input  logic                DadoEntradaValido_i,
  output logic                DadoEntradaAceito_o,
  output logic [7:0]          DadoSaida_o,
  output logic                DadoSaidaValido_o,
  output logic                Ocupado_o,
  output logic                Concluido_o,
  output logic [7:0]          Endereco_o,
  output logic [7:0]          DadoEscritoMem_o,
  output logic                EscMem_o,
  output logic                LerMem_o,
  input  logic [7:0]          DadoLidoMem_i
);

  typedef enum logic [2:0] {
    OCIOSO,
    LEITURA,
    ESPERA_DADO,
    ESCRITA,
    FIM
  } estado_t;

  localparam logic [LARG_QTD-1:0] QTD_UM = LARG_QTD'(1);

  estado_t             estado_q, estado_d;
  logic [7:0]          addr_q, addr_d;
  logic [LARG_QTD-1:0] rest_q, rest_d;
  logic [7:0]          endereco_q, endereco_d;
  logic [7:0]          dado_esc_q, dado_esc_d;
  logic                esc_mem_q, esc_mem_d;
  logic                ler_mem_q, ler_mem_d;
  logic [7:0]          dado_saida_q, dado_saida_d;
  logic                saida_valido_q, saida_valido_d;

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      estado_q       <= OCIOSO;
      addr_q         <= 8'h00;
      rest_q         <= '0;
      endereco_q     <= 8'h00;
      dado_esc_q     <= 8'h00;
      esc_mem_q      <= 1'b0;
      ler_mem_q      <= 1'b0;
      dado_saida_q   <= 8'h00;
      saida_valido_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      addr_q         <= addr_d;
      rest_q         <= rest_d;
      endereco_q     <= endereco_d;
      dado_esc_q     <= dado_esc_d;
      esc_mem_q      <= esc_mem_d;
      ler_mem_q      <= ler_mem_d;
      dado_saida_q   <= dado_saida_d;
      saida_valido_q <= saida_valido_d;
    end
  end

  // Strobes are registered, so they are decided one cycle ahead of the state they belong to.
  always_comb begin
    estado_d       = estado_q;
    addr_d         = addr_q;
    rest_d         = rest_q;
    endereco_d     = endereco_q;
    dado_esc_d     = dado_esc_q;
    esc_mem_d      = 1'b0;
    ler_mem_d      = 1'b0;
    dado_saida_d   = dado_saida_q;
    saida_valido_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (Inicio_i) begin
          addr_d = EnderecoBase_i;
          rest_d = Quantidade_i;
          if (Quantidade_i == '0) begin
            estado_d = FIM;
          end else if (!Escrita_i) begin
            estado_d   = LEITURA;
            ler_mem_d  = 1'b1;
            endereco_d = EnderecoBase_i;
          end else begin
            estado_d = ESPERA_DADO;
          end
        end
      end
      LEITURA: begin
        // Memory updated DadoLidoMem on the falling edge of this cycle.
        dado_saida_d   = DadoLidoMem_i;
        saida_valido_d = 1'b1;
        addr_d         = addr_q + 8'd1;
        rest_d         = rest_q - QTD_UM;
        if (rest_q == QTD_UM) begin
          estado_d = FIM;
        end else begin
          ler_mem_d  = 1'b1;
          endereco_d = addr_q + 8'd1;
        end
      end
      ESPERA_DADO: begin
        if (DadoEntradaValido_i) begin
          dado_esc_d = DadoEntrada_i;
          endereco_d = addr_q;
          esc_mem_d  = 1'b1;
          estado_d   = ESCRITA;
        end
      end
      ESCRITA: begin
        addr_d = addr_q + 8'd1;
        rest_d = rest_q - QTD_UM;
        if (rest_q == QTD_UM) begin
          estado_d = FIM;
        end else begin
          estado_d = ESPERA_DADO;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign DadoEntradaAceito_o = (estado_q == ESPERA_DADO);
  assign Ocupado_o           = (estado_q != OCIOSO);
  assign Concluido_o         = (estado_q == FIM);
  assign DadoSaida_o         = dado_saida_q;
  assign DadoSaidaValido_o   = saida_valido_q;
  assign Endereco_o          = endereco_q;
  assign DadoEscritoMem_o    = dado_esc_q;
  assign EscMem_o            = esc_mem_q;
  assign LerMem_o            = ler_mem_q;

endmodule

// File: tb/tb_controlador_memoria.sv
// Directed bench for controlador_memoria: a memory model plus per-cycle scoreboards of
// expected reads, writes, load data and completions, all timed relative to the request edge.
module tb_controlador_memoria;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio, escrita, din_valido, din_aceito;
  logic [7:0] base, din, dout, endereco, dado_mem, dado_lido;
  logic [4:0] qtd;
  logic       dout_valido, ocupado, concluido, esc_mem, ler_mem;

  logic [7:0] mem [256];

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_wr[$];
  ev_t q_out[$];
  ev_t q_done[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start = 0;

  controlador_memoria #(.LARG_QTD(5)) dut (
    .Clock_i            (clk),
    .Reset_i            (rst),
    .Inicio_i           (inicio),
    .Escrita_i          (escrita),
    .EnderecoBase_i     (base),
    .Quantidade_i       (qtd),
    .DadoEntrada_i      (din),
    .DadoEntradaValido_i(din_valido),
    .DadoEntradaAceito_o(din_aceito),
    .DadoSaida_o        (dout),
    .DadoSaidaValido_o  (dout_valido),
    .Ocupado_o          (ocupado),
    .Concluido_o        (concluido),
    .Endereco_o         (endereco),
    .DadoEscritoMem_o   (dado_mem),
    .EscMem_o           (esc_mem),
    .LerMem_o           (ler_mem),
    .DadoLidoMem_i      (dado_lido)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: writes on the rising edge, reads on the falling edge.
  always @(posedge clk) if (esc_mem === 1'b1) mem[endereco] = dado_mem;
  always @(negedge clk) if (ler_mem === 1'b1) dado_lido = mem[endereco];

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Output monitor: every strobe/pulse must match the head of its scoreboard queue.
  always @(negedge clk) begin
    int rel;
    ev_t e;
    rel = cyc - start;
    if (esc_mem === 1'b1 && ler_mem === 1'b1) chk("strobes_exclusive", 32'd1, 32'd0);
    if (ler_mem === 1'b1) begin
      if (q_rd.size() == 0) chk("rd_unexpected", 32'(q_rd.size()), 32'd1);
      else begin
        e = q_rd.pop_front();
        $display("rd  cyc=%0d addr=%02h", rel, endereco);
        chk("rd_cycle", 32'(rel), 32'(e.cyc));
        chk("rd_addr", {24'd0, endereco}, 32'(e.addr));
      end
    end
    if (esc_mem === 1'b1) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 32'(q_wr.size()), 32'd1);
      else begin
        e = q_wr.pop_front();
        $display("wr  cyc=%0d addr=%02h data=%02h", rel, endereco, dado_mem);
        chk("wr_cycle", 32'(rel), 32'(e.cyc));
        chk("wr_addr", {24'd0, endereco}, 32'(e.addr));
        chk("wr_data", {24'd0, dado_mem}, 32'(e.data));
      end
    end
    if (dout_valido === 1'b1) begin
      if (q_out.size() == 0) chk("out_unexpected", 32'(q_out.size()), 32'd1);
      else begin
        e = q_out.pop_front();
        $display("out cyc=%0d data=%02h", rel, dout);
        chk("out_cycle", 32'(rel), 32'(e.cyc));
        chk("out_data", {24'd0, dout}, 32'(e.data));
      end
    end
    if (concluido === 1'b1) begin
      if (q_done.size() == 0) chk("done_unexpected", 32'(q_done.size()), 32'd1);
      else begin
        e = q_done.pop_front();
        $display("done cyc=%0d", rel);
        chk("done_cycle", 32'(rel), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic exp_ev(input int kind, input int c, input int a, input int d);
    ev_t e;
    e.cyc = c; e.addr = a; e.data = d;
    case (kind)
      0: q_rd.push_back(e);
      1: q_wr.push_back(e);
      2: q_out.push_back(e);
      default: q_done.push_back(e);
    endcase
  endtask

  // Drive one request; Inicio is sampled at the next edge ("edge 0"), returns in cycle 1.
  task automatic start_req(input logic wr, input logic [7:0] b, input logic [4:0] n);
    inicio = 1'b1; escrita = wr; base = b; qtd = n;
    start = cyc;
    tick();
    inicio = 1'b0;
  endtask

  task automatic drain(input string tag);
    ticks(4);
    chk({tag, "_rd_left"}, 32'(q_rd.size()), 32'd0);
    chk({tag, "_wr_left"}, 32'(q_wr.size()), 32'd0);
    chk({tag, "_out_left"}, 32'(q_out.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(q_done.size()), 32'd0);
    chk({tag, "_idle"}, {31'd0, ocupado}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_aceito"}, {31'd0, din_aceito}, 32'd0);
    chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
    chk({tag, "_dout_valido"}, {31'd0, dout_valido}, 32'd0);
    chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
    chk({tag, "_concluido"}, {31'd0, concluido}, 32'd0);
    chk({tag, "_endereco"}, {24'd0, endereco}, 32'd0);
    chk({tag, "_dado_mem"}, {24'd0, dado_mem}, 32'd0);
    chk({tag, "_esc_mem"}, {31'd0, esc_mem}, 32'd0);
    chk({tag, "_ler_mem"}, {31'd0, ler_mem}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    dado_lido = 8'h00;
    rst = 1'b1; inicio = 1'b0; escrita = 1'b0; base = 8'h00; qtd = 5'd0;
    din = 8'h00; din_valido = 1'b0;
    ticks(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Load burst 0x10, 3 words.
    for (int i = 0; i < 3; i++) exp_ev(0, 1 + i, 8'h10 + i, 0);
    exp_ev(2, 2, 0, 8'hA1); exp_ev(2, 3, 0, 8'hB2); exp_ev(2, 4, 0, 8'hC3);
    exp_ev(3, 4, 0, 0);
    start_req(1'b0, 8'h10, 5'd3);
    chk("load_ocupado_c1", {31'd0, ocupado}, 32'd1);
    drain("load3");

    // Store 0x20, 2 words, valid held high.
    exp_ev(1, 2, 8'h20, 8'h55); exp_ev(1, 4, 8'h21, 8'h66); exp_ev(3, 5, 0, 0);
    din = 8'h55; din_valido = 1'b1;
    start_req(1'b1, 8'h20, 5'd2);
    ticks(2);
    din = 8'h66;
    ticks(3);
    din_valido = 1'b0;
    drain("store2");

    // Read the stored words back.
    exp_ev(0, 1, 8'h20, 0); exp_ev(0, 2, 8'h21, 0);
    exp_ev(2, 2, 0, 8'h55); exp_ev(2, 3, 0, 8'h66); exp_ev(3, 3, 0, 0);
    start_req(1'b0, 8'h20, 5'd2);
    drain("readback");

    // Store with valid delayed: waits in ESPERA_DADO, then a single write.
    exp_ev(1, 5, 8'h30, 8'h77); exp_ev(3, 6, 0, 0);
    din = 8'h77;
    start_req(1'b1, 8'h30, 5'd1);
    for (int i = 1; i <= 3; i++) begin
      chk("wait_aceito", {31'd0, din_aceito}, 32'd1);
      chk("wait_esc_mem", {31'd0, esc_mem}, 32'd0);
      tick();
    end
    chk("wait_aceito_c4", {31'd0, din_aceito}, 32'd1);
    din_valido = 1'b1;
    tick();
    din_valido = 1'b0;
    chk("escrita_aceito_low", {31'd0, din_aceito}, 32'd0);
    chk("escrita_esc_mem", {31'd0, esc_mem}, 32'd1);
    drain("store_wait");

    // Load across the address wrap.
    exp_ev(0, 1, 8'hFE, 0); exp_ev(0, 2, 8'hFF, 0); exp_ev(0, 3, 8'h00, 0);
    exp_ev(2, 2, 0, 8'h11); exp_ev(2, 3, 0, 8'h22); exp_ev(2, 4, 0, 8'h33);
    exp_ev(3, 4, 0, 0);
    start_req(1'b0, 8'hFE, 5'd3);
    drain("wrap");

    // Zero-length request: immediate completion, no strobes.
    exp_ev(3, 1, 0, 0);
    start_req(1'b1, 8'h50, 5'd0);
    chk("qty0_ocupado_c1", {31'd0, ocupado}, 32'd1);
    tick();
    chk("qty0_ocupado_c2", {31'd0, ocupado}, 32'd0);
    drain("qty0");

    // Inicio pulsed mid-burst must be ignored.
    for (int i = 0; i < 3; i++) exp_ev(0, 1 + i, 8'h10 + i, 0);
    exp_ev(2, 2, 0, 8'hA1); exp_ev(2, 3, 0, 8'hB2); exp_ev(2, 4, 0, 8'hC3);
    exp_ev(3, 4, 0, 0);
    start_req(1'b0, 8'h10, 5'd3);
    tick();
    inicio = 1'b1; escrita = 1'b1; base = 8'h60; qtd = 5'd0;
    tick();
    inicio = 1'b0;
    drain("ignored_inicio");

    // Reset during the ESCRITA of word 2 of a 4-word store.
    mem[8'h42] = 8'hEE; mem[8'h43] = 8'hEE;
    exp_ev(1, 2, 8'h40, 8'h91); exp_ev(1, 4, 8'h41, 8'h92);
    din = 8'h91; din_valido = 1'b1;
    start_req(1'b1, 8'h40, 5'd4);
    ticks(2);
    din = 8'h92;
    tick();
    chk("pre_reset_esc_mem", {31'd0, esc_mem}, 32'd1);
    rst = 1'b1;
    din = 8'h93;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    din_valido = 1'b0;
    drain("midreset");
    chk("mem_40", {24'd0, mem[8'h40]}, 32'h91);
    chk("mem_41", {24'd0, mem[8'h41]}, 32'h92);
    chk("mem_42", {24'd0, mem[8'h42]}, 32'hEE);
    chk("mem_43", {24'd0, mem[8'h43]}, 32'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
